// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution frame sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // ceil(log2(v)), never below 1 so a degenerate range still gets a 1-bit field.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int b = 1; b < 31; b++)
      if ((1 << b) < v) r = b + 1;
    return r;
  endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Control/read/tap bundle between the frame sequencer and its neighbours.
interface conv_sched_if #(
  parameter int AW = 14,
  parameter int CW = 4
);
  logic          start_i;
  logic          hold_i;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic          tap_valid_o;
  logic          tap_first_o;
  logic          tap_last_o;
  logic [CW-1:0] coef_idx_o;
  logic          running_o;
  logic          done_o;

  modport master (
    output start_i, hold_i,
    input  rd_en_o, rd_addr_o, tap_valid_o, tap_first_o, tap_last_o,
           coef_idx_o, running_o, done_o
  );

  modport slave (
    input  start_i, hold_i,
    output rd_en_o, rd_addr_o, tap_valid_o, tap_first_o, tap_last_o,
           coef_idx_o, running_o, done_o
  );
endinterface

// File: rtl/conv_addr_gen.sv
// Tap/pixel counters with incremental address formation: addr = pix_base + row_off + j.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int N  = 100,
  parameter int K  = 3,
  parameter int AW = clog2(N * N),
  parameter int CW = clog2(K * K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] tap,
  output logic          pix_start,
  output logic          pix_last,
  output logic          frame_last
);

  localparam logic [CW-1:0] KM1   = CW'(K - 1);
  localparam logic [AW-1:0] MM1   = AW'(N - K);
  localparam logic [AW-1:0] NSTEP = AW'(N);
  localparam logic [AW-1:0] KSTEP = AW'(K);

  logic [CW-1:0] j, i;
  logic [AW-1:0] c, r;
  logic [AW-1:0] pix_base, row_off;

  logic j_last, i_last, c_last, r_last;

  assign j_last     = (j == KM1);
  assign i_last     = (i == KM1);
  assign c_last     = (c == MM1);
  assign r_last     = (r == MM1);
  assign pix_start  = (j == '0) && (i == '0);
  assign pix_last   = j_last && i_last;
  assign frame_last = pix_last && c_last && r_last;
  assign addr       = pix_base + row_off + AW'(j);

  always_ff @(posedge clk) begin
    if (rst) begin
      j        <= '0;
      i        <= '0;
      c        <= '0;
      r        <= '0;
      tap      <= '0;
      pix_base <= '0;
      row_off  <= '0;
    end else if (advance) begin
      tap <= pix_last ? '0 : tap + 1'b1;
      if (!j_last) begin
        j <= j + 1'b1;
      end else begin
        j <= '0;
        if (!i_last) begin
          i       <= i + 1'b1;
          row_off <= row_off + NSTEP;
        end else begin
          i       <= '0;
          row_off <= '0;
          if (!c_last) begin
            c        <= c + 1'b1;
            pix_base <= pix_base + 1'b1;
          end else begin
            c <= '0;
            // base of (r,M-1) plus K lands on the base of (r+1,0)
            if (!r_last) begin
              r        <= r + 1'b1;
              pix_base <= pix_base + KSTEP;
            end else begin
              r        <= '0;
              pix_base <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Frame sequencer: issues K*K reads per output pixel and emits tap strobes aligned to 1-cycle memory data.
module conv_sched
  import conv_pkg::*;
#(
  parameter int N  = 100,
  parameter int K  = 3,
  parameter int AW = clog2(N * N),
  parameter int CW = clog2(K * K)
) (
  input  logic clk,
  input  logic rst,
  conv_sched_if.slave bus
);

  state_t        state;
  logic [AW-1:0] addr;
  logic [CW-1:0] tap;
  logic          pix_start, pix_last, frame_last;
  logic          rd_en;

  logic          tap_valid, tap_first, tap_last;
  logic [CW-1:0] coef_idx;

  // back-pressure only bites on a pixel boundary so a started pixel never splits
  assign rd_en = (state == ISSUE) && !(pix_start && bus.hold_i);

  conv_addr_gen #(.N(N), .K(K), .AW(AW), .CW(CW)) u_addr (
    .clk        (clk),
    .rst        (rst),
    .advance    (rd_en),
    .addr       (addr),
    .tap        (tap),
    .pix_start  (pix_start),
    .pix_last   (pix_last),
    .frame_last (frame_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start_i) state <= ISSUE;
        ISSUE:   if (rd_en && frame_last) state <= FLUSH;
        FLUSH:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_valid <= 1'b0;
      tap_first <= 1'b0;
      tap_last  <= 1'b0;
      coef_idx  <= '0;
    end else begin
      tap_valid <= rd_en;
      tap_first <= rd_en && pix_start;
      tap_last  <= rd_en && pix_last;
      coef_idx  <= rd_en ? tap : '0;
    end
  end

  assign bus.rd_en_o     = rd_en;
  assign bus.rd_addr_o   = rd_en ? addr : '0;
  assign bus.tap_valid_o = tap_valid;
  assign bus.tap_first_o = tap_first;
  assign bus.tap_last_o  = tap_last;
  assign bus.coef_idx_o  = coef_idx;
  assign bus.running_o   = (state == ISSUE) || (state == FLUSH);
  assign bus.done_o      = (state == DONE);

endmodule

// File: doc/conv_sched.md
# conv_sched

Frame sequencer for the convolution datapath. On `start_i` it walks every valid output position of an N×N row-major image with a K×K kernel, issuing K·K image-memory reads per output pixel. It emits tap strobes aligned to the returning memory data so the MAC datapath can clear, accumulate and close each output. It sits between the image memory and the MAC/coefficient block, and owns the frame-level `running_o` flag.

## Interface
- `N`, 100, image width and height in pixels (K ≤ N)
- `K`, 3, kernel size (≥ 1)
- `AW`, 14, read-address width (≥ clog2(N·N))
- `CW`, 4, coefficient-index width (≥ clog2(K·K), minimum 1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start_i`  in  1  begin a frame; honoured only in IDLE
- `hold_i`  in  1  downstream back-pressure; sampled only at output-pixel boundaries
- `rd_en_o`  out  1  image-memory read strobe
- `rd_addr_o`  out  AW  read address
- `tap_valid_o`  out  1  memory data for a tap is valid this cycle (`rd_en_o` delayed 1)
- `tap_first_o`  out  1  first tap of an output pixel (MAC clear-and-load)
- `tap_last_o`  out  1  last tap of an output pixel (MAC result complete)
- `coef_idx_o`  out  CW  kernel coefficient index i·K+j, aligned with `tap_valid_o`
- `running_o`  out  1  frame in progress
- `done_o`  out  1  one-cycle pulse at frame end

## Operation
- M = N−K+1 outputs per row and column. Output (r,c), tap (i,j) reads address (r+i)·N + (c+j). Tap order is j fastest, then i. Pixels are visited in raster order, c fastest.
- Addresses are formed incrementally: a pixel-base register plus a row-offset register stepped by N. No multipliers.
- States:
  - IDLE: all strobes 0. `start_i` → ISSUE.
  - ISSUE: one read per cycle. After the final tap of pixel (M−1,M−1) → FLUSH.
  - FLUSH: no read; the last `tap_valid_o` and `tap_last_o` appear. → DONE.
  - DONE: `done_o` = 1 for one cycle. → IDLE.
- hold rule:
  - In ISSUE, on a cycle whose read would be tap 0 of a pixel (including the first pixel), `hold_i`=1 gives `rd_en_o`=0 with counters and address frozen.
  - `hold_i` is ignored on taps 1..K·K−1. A started pixel always completes contiguously.
- `start_i` outside IDLE is ignored, including in DONE.
- K=1: every tap has `tap_first_o` = `tap_last_o` = 1, and `coef_idx_o` is 0.
- `rst` mid-frame: the next cycle is IDLE with all outputs 0 and delayed tap registers cleared. No `done_o`.

## Timing
- Reset value of every output is 0. `rd_addr_o` and `coef_idx_o` are 0 whenever their strobe is 0.
- `start_i` at cycle t gives the first `rd_en_o`, addr 0, at t+1.
- Memory latency is fixed at 1. `tap_*` and `coef_idx_o` are registered copies of the issue-side values, so a read at cycle u has its tap at u+1.
- `running_o` is 1 from the first ISSUE cycle through the FLUSH cycle inclusive. `done_o` is asserted in the following cycle with `running_o`=0.
- With no hold, ISSUE lasts M²·K² cycles (N=100, K=3: 86 436). Each held boundary cycle adds 1.
- Counter wrap:
  - j wraps at K−1 → i++.
  - i wraps → c++.
  - c wraps at M−1 → r++.
  - r=M−1 wrap → FLUSH.

## Structure
- `conv_pkg` holds the state enum (IDLE, ISSUE, FLUSH, DONE) and a clog2 helper function used to size `AW` and `CW`.
- Sub-module `conv_addr_gen` holds the i/j/c/r counters and incremental address registers, with an `advance` input and `pix_start`/`frame_last` flags.
- `conv_sched` holds the FSM, the hold gating and the 1-cycle tap-alignment stage.

## Test plan
- N=5, K=3, no hold → 81 reads.
  - Pixel (0,0) addrs 0,1,2,5,6,7,10,11,12.
  - Pixel (0,1) starts at 1.
  - Last pixel addrs 12,13,14,17,18,19,22,23,24.
  - `coef_idx_o` cycles 0..8; 9 `tap_first_o` and 9 `tap_last_o`.
  - `done_o` exactly 2 cycles after the last `rd_en_o`.
- N=5, K=3, `hold_i`=1 for 3 cycles starting at pixel (1,0) tap 0 → `rd_en_o` low 3 cycles, then addr 5 resumes.
  - Same `hold_i` pulse applied during tap 4 → no effect.
- N=4, K=1 → addrs 0..15 contiguous, `tap_first_o` = `tap_last_o` = 1 on all 16 taps.
- `start_i` pulsed again mid-frame and in the DONE cycle → no restart, single `done_o`.
- `rst` at read 40 of an N=5, K=3 frame → next cycle all outputs 0. A new `start_i` restarts at addr 0.
- N=100, K=3 full frame → 86 436 taps, final addr 9999, `running_o` high for 86 437 cycles.
